stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Four-digit BCD stopwatch controller that sequences a run/pause/clear state machine. It derives a count tick from the system clock and cascades four decimal digits. It also time-multiplexes one shared `segment7` decoder across four common-anode display digits. It sits between board push-button pulse logic and the seven-segment pins, replacing the single-digit free-running counter-to-decoder path.

## Interface
- `TICK_DIV`, 500000, clock cycles per count increment (100 Hz at 50 MHz); must be ≥ 2
- `SCAN_DIV`, 50000, clock cycles per display digit slot; must be ≥ 2
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `start_stop`  in  1  single-cycle pulse: start / pause / resume
- `clear`  in  1  single-cycle pulse: zero the count
- `seg`  out  7  segment drive {g,f,e,d,c,b,a}, active-low, registered
- `an`  out  4  digit enable, active-low one-cold, registered; bit 0 = least significant digit
- `digits`  out  16  BCD count {d3,d2,d1,d0}, registered
- `running`  out  1  high while in RUN
- `overflow`  out  1  sticky; set on 9999→0000 wrap

## Operation
- Reset values: state IDLE, `digits`=16'h0000, `running`=0, `overflow`=0, `an`=4'b1110, `seg`=7'b1000000, prescaler=0, scan counter=0, digit index=0.
- States:
  - IDLE: count is zero and the prescaler is held at 0.
  - RUN: the prescaler counts.
  - PAUSE: the count and the prescaler phase are both frozen.
- Transitions:
  - IDLE + `start_stop` → RUN.
  - RUN + `start_stop` → PAUSE.
  - PAUSE + `start_stop` → RUN.
  - PAUSE + `clear` → IDLE.
  - IDLE + `clear` → IDLE, with `overflow` cleared.
- `clear` in RUN is ignored. When `start_stop` and `clear` arrive in the same cycle:
  - in IDLE or PAUSE, `clear` wins;
  - in RUN, `start_stop` acts.
- Entering IDLE zeroes `digits`, the prescaler and `overflow`.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1 and wraps.
  - The internal `tick` is high when the prescaler equals TICK_DIV-1 in RUN.
  - Leaving RUN holds the current prescaler value.
- BCD cascade on `tick`:
  - d0 increments.
  - Digit k wraps 9→0 and carries into digit k+1 only when all lower digits are 9.
  - 9999 → 0000 sets `overflow`; counting continues.
  - Digit values are never outside 0..9.
- Scan:
  - The scan counter is free-running in every state, counting 0..SCAN_DIV-1.
  - At terminal count the digit index advances 0→1→2→3→0.
- Display outputs:
  - `an` = ~(1 << index).
  - `seg` = decode(digit[index]), using the existing 0–F active-low map (0=7'b1000000, 1=7'b1111001, … 9=7'b0010000).
  - `seg` and `an` are registered together so they always change in the same cycle; there is no ghosting between digits.
- `running` is a registered decode of state == RUN.

## Timing
- `start_stop` sampled at edge N (in IDLE) → `running`=1 after edge N.
- The first `digits` increment is visible TICK_DIV cycles after `running` rises. Subsequent increments occur every TICK_DIV cycles.
- `digits` updates on the edge following the cycle in which `tick` is high: one cycle of latency.
- Pause then resume: the total RUN cycles between increments equal exactly TICK_DIV, because phase is preserved.
- `clear` in PAUSE sampled at edge N → `digits`=0, `running`=0 after edge N.
- The display slot lasts SCAN_DIV cycles. `seg`/`an` reflect `digits` with at most one cycle of extra latency.
- `rst` asserted mid-RUN → all outputs take their reset values after the next edge, regardless of other inputs.
- Inputs are assumed synchronous, single-cycle pulses. Held-high inputs toggle the state on every cycle; that is by definition, not debounced here.

## Structure
- A shared package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2; 2'd3 recovers to IDLE);
  - the BCD max constant 4'd9;
  - the digit count constant 4.
- The single sub-module is the existing `segment7` decoder, instantiated once and fed by the scan mux. Its output is registered in `stopwatch_ctrl`.
- FSM, prescaler, BCD cascade and scan counter are in `stopwatch_ctrl`.

## Test plan
Benches use TICK_DIV=4, SCAN_DIV=2.
- Reset, then idle 20 cycles → `digits`=0, `running`=0, `an` cycles 1110→1101→1011→0111 every 2 cycles, `seg`=7'b1000000 throughout.
- `start_stop` pulse, run 40 cycles → `digits`=16'h0010, with an increment every 4 cycles.
- Pulse `start_stop` to pause at prescaler=2, wait 10 cycles, pulse to resume → next increment comes exactly 2 cycles after `running` rises.
- Preload to 0999 by running → next tick yields 16'h1000. Run to 9999 → next tick yields 0000 and `overflow`=1.
- `clear` during RUN → ignored. `start_stop`+`clear` in the same cycle while in PAUSE → IDLE, `digits`=0, `overflow`=0.
- `rst` asserted mid-RUN with `start_stop` high → all outputs return to their reset values after one edge.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the four-digit BCD stopwatch: state encoding,
// digit limits and the BCD increment helper used by the count cascade.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StInvalid = 2'd3
  } state_t;

  localparam logic [3:0] BcdMax    = 4'd9;
  localparam int         NumDigits = 4;

  // Increments a packed four-digit BCD value; bit 16 of the result is the
  // carry out of the top digit, i.e. the 9999 -> 0000 wrap.
  function automatic logic [16:0] bcdInc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    for (int k = 0; k < NumDigits; k++) begin
      if (carry) begin
        if (value[4*k +: 4] >= BcdMax) begin
          result[4*k +: 4] = 4'd0;
        end else begin
          result[4*k +: 4] = value[4*k +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return {carry, result};
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_segment7.sv
// Hex-to-seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module segment7 (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Pure lookup of the 0-F glyph for the selected digit.
  always_comb begin
    seg_o = 7'b1111111;
    case (bcd_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch: run/pause/clear FSM, count prescaler, decimal
// cascade and a time-multiplexed common-anode display driver.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] digits,
  output logic        running,
  output logic        overflow
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] ScanLast  = SW'(SCAN_DIV - 1);

  state_t        state_q;
  logic          running_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   digits_q;
  logic          overflow_q;
  logic [SW-1:0] scanCnt_q;
  logic [1:0]    digitIdx_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  logic          tick;
  logic          goIdle;
  logic [16:0]   incResult;
  logic [3:0]    scanDigit;
  logic [6:0]    segDecoded;

  assign tick      = (state_q == StRun) && (presc_q == PrescLast);
  assign incResult = bcdInc(digits_q);
  assign scanDigit = digits_q[{digitIdx_q, 2'b00} +: 4];

  // Clear only acts outside RUN; the unused encoding also falls back to IDLE.
  always_comb begin
    goIdle = 1'b0;
    case (state_q)
      StIdle, StPause: goIdle = clear;
      StRun:           goIdle = 1'b0;
      default:         goIdle = 1'b1;
    endcase
  end

  // Run/pause/clear state machine with the running flag registered alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!clear && start_stop) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (start_stop) begin
            state_q   <= StPause;
            running_q <= 1'b0;
          end
        end
        StPause: begin
          if (clear) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end else if (start_stop) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler and BCD count; phase is kept across pauses so resumes are exact.
  always_ff @(posedge clk) begin
    if (rst || goIdle) begin
      presc_q    <= '0;
      digits_q   <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == StRun) begin
        presc_q <= (presc_q == PrescLast) ? '0 : presc_q + PW'(1);
      end
      if (tick) begin
        digits_q <= incResult[15:0];
        if (incResult[16]) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Free-running display scan; seg and an are registered in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scanCnt_q  <= '0;
      digitIdx_q <= 2'd0;
      an_q       <= 4'b1110;
      seg_q      <= 7'b1000000;
    end else begin
      scanCnt_q <= (scanCnt_q == ScanLast) ? '0 : scanCnt_q + SW'(1);
      if (scanCnt_q == ScanLast) begin
        digitIdx_q <= digitIdx_q + 2'd1;
      end
      an_q  <= ~(4'b0001 << digitIdx_q);
      seg_q <= segDecoded;
    end
  end

  segment7 u_segment7 (
    .bcd_i (scanDigit),
    .seg_o (segDecoded)
  );

  assign seg      = seg_q;
  assign an       = an_q;
  assign digits   = digits_q;
  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: the driver advances an integer-count
// reference model each cycle and queues the expected outputs; a monitor
// compares them against the DUT one step after every rising edge.
module tb_stopwatch_ctrl;

  localparam int TickDiv = 4;
  localparam int ScanDiv = 2;

  localparam logic [6:0] SegMap [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    logic [15:0] digits;
    logic        running;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        start_stop;
  logic        clear;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        running;
  logic        overflow;

  expect_t expQ[$];
  int total = 0;
  int bad   = 0;

  // Reference model: 0 = idle, 1 = run, 2 = pause
  int mMode  = 0;
  int mCount = 0;
  int mPhase = 0;
  int mOvf   = 0;
  int mEdges = 0;

  stopwatch_ctrl #(
    .TICK_DIV (TickDiv),
    .SCAN_DIV (ScanDiv)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .seg        (seg),
    .an         (an),
    .digits     (digits),
    .running    (running),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] toBcd(input int c);
    logic [15:0] r;
    r[15:12] = 4'((c / 1000) % 10);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, step the model, queue expectations.
  task automatic applyStimulus(input bit r, input bit ss, input bit cl);
    expect_t     e;
    logic [15:0] prevBcd;
    logic [3:0]  nib;
    int          prevIdx;
    @(negedge clk);
    rst        = r;
    start_stop = ss;
    clear      = cl;
    prevBcd    = toBcd(mCount);
    prevIdx    = (mEdges / ScanDiv) % 4;
    if (r) begin
      mMode  = 0;
      mCount = 0;
      mPhase = 0;
      mOvf   = 0;
      mEdges = 0;
      e.an   = 4'b1110;
      e.seg  = 7'b1000000;
    end else begin
      if (mMode == 1) begin
        if (mPhase == TickDiv - 1) begin
          mCount++;
          if (mCount == 10000) begin
            mCount = 0;
            mOvf   = 1;
          end
        end
        mPhase = (mPhase + 1) % TickDiv;
      end
      if (mMode != 1 && cl) begin
        mMode  = 0;
        mCount = 0;
        mPhase = 0;
        mOvf   = 0;
      end else if (ss) begin
        mMode = (mMode == 1) ? 2 : 1;
      end
      mEdges++;
      nib   = prevBcd[4*prevIdx +: 4];
      e.an  = ~(4'b0001 << prevIdx);
      e.seg = SegMap[nib];
    end
    e.digits   = toBcd(mCount);
    e.running  = (mMode == 1);
    e.overflow = (mOvf != 0);
    expQ.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle, so pop one entry per edge.
  always @(posedge clk) begin
    expect_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("digits",   digits,           e.digits);
      checkOutput("running",  16'(running),     16'(e.running));
      checkOutput("overflow", 16'(overflow),    16'(e.overflow));
      checkOutput("an",       16'(an),          16'(e.an));
      checkOutput("seg",      16'(seg),         16'(e.seg));
    end
  end

  initial begin
    rst        = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;

    $display("[TB] reset and idle scan");
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0);

    $display("[TB] run 40 cycles");
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0);

    $display("[TB] pause mid-phase and resume");
    for (int g = 0; g < TickDiv && mPhase != 1; g++) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0);

    $display("[TB] clear during run is ignored");
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0);

    $display("[TB] run through 0999 and 9999");
    for (int g = 0; g < 50000 && mCount != 999; g++) applyStimulus(0, 0, 0);
    for (int i = 0; i < 2 * TickDiv; i++) applyStimulus(0, 0, 0);
    for (int g = 0; g < 50000 && mCount != 9999; g++) applyStimulus(0, 0, 0);
    for (int i = 0; i < 3 * TickDiv; i++) applyStimulus(0, 0, 0);

    $display("[TB] pause then start_stop with clear");
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 0);

    $display("[TB] randomized pulses");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0));
    end

    $display("[TB] reset mid-run with start_stop high");
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0);

    @(posedge clk);
    #3;
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
